// File: rtl/commit_queue.sv
// commit_queue: in-order buffer between the WB stage and the commit sink.
// Checks that retire sequence numbers are contiguous, counts retired records,
// and freezes intake once the halt trap instruction has been accepted.
module commit_queue #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] HALT_INST = 32'h0005006b
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic [63:0] in_pc,
   input  logic [63:0] in_counter,
   input  logic        in_wen,
   input  logic [4:0]  in_wdst,
   input  logic [63:0] in_wdata,
   input  logic        in_jump_en,
   input  logic [63:0] in_jump_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [63:0] out_pc,
   output logic [63:0] out_counter,
   output logic        out_wen,
   output logic [4:0]  out_wdst,
   output logic [63:0] out_wdata,
   output logic        out_jump_en,
   output logic [63:0] out_jump_target,
   output logic [63:0] retired,
   output logic        seq_err,
   output logic        halted
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] pc;
      logic [63:0] counter;
      logic        wen;
      logic [4:0]  wdst;
      logic [63:0] wdata;
      logic        jump_en;
      logic [63:0] jump_target;
   } rec_t;

   rec_t          mem [DEPTH];
   rec_t          in_rec;
   rec_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [63:0]   expected;
   logic          halt_seen;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   // intake never looks at out_ready, so a full queue stays closed for a cycle
   assign in_ready  = !full && !halt_seen;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Pack the incoming record; writes to x0 are architecturally invisible
   always_comb begin
      in_rec             = '0;
      in_rec.inst        = in_inst;
      in_rec.pc          = in_pc;
      in_rec.counter     = in_counter;
      in_rec.wen         = in_wen && (in_wdst != 5'd0);
      in_rec.wdst        = in_wdst;
      in_rec.wdata       = in_wdata;
      in_rec.jump_en     = in_jump_en;
      in_rec.jump_target = in_jump_target;
   end

   // Storage array; contents are don't-care while the slot is unoccupied
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_rec;
   end

   // Pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Head view; zeroed when empty so the sink never sees a stale record
   always_comb begin
      head = '0;
      if (!empty) head = mem[rd_ptr];
   end

   assign out_inst        = head.inst;
   assign out_pc          = head.pc;
   assign out_counter     = head.counter;
   assign out_wen         = head.wen;
   assign out_wdst        = head.wdst;
   assign out_wdata       = head.wdata;
   assign out_jump_en     = head.jump_en;
   assign out_jump_target = head.jump_target;

   // Sequence check and halt detection on accepted records
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         expected  <= '0;
         seq_err   <= 1'b0;
         halt_seen <= 1'b0;
      end else if (push) begin
         if (in_counter != expected) seq_err <= 1'b1;
         expected <= in_counter + 64'd1;
         if (in_inst == HALT_INST) halt_seen <= 1'b1;
      end
   end

   // Retire counting and halt reporting on popped records
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retired <= '0;
         halted  <= 1'b0;
      end else if (pop) begin
         retired <= retired + 64'd1;
         if (head.inst == HALT_INST) halted <= 1'b1;
      end
   end

endmodule

// File: doc/commit_queue.md
Name: commit_queue

Overview:
- Consumer end of the writeback-to-commit record: receives one retired-instruction record per cycle from the WB stage.
- Buffers records in a small in-order FIFO and presents them one at a time to the difftest/commit sink.
- Checks that the instruction counter sequence is contiguous and counts retired instructions.
- Detects the halt trap and freezes after it.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- HALT_INST, 32'h0005006b, instruction encoding that terminates simulation.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  WB presents a record
- in_ready  out  1  queue accepts a record this cycle
- in_inst  in  32  instruction word
- in_pc  in  64  instruction PC
- in_counter  in  64  sequence number assigned at fetch
- in_wen  in  1  register write enable
- in_wdst  in  5  destination register
- in_wdata  in  64  write data
- in_jump_en  in  1  instruction redirected the PC
- in_jump_target  in  64  redirect target
- out_valid  out  1  head record valid
- out_ready  in  1  sink consumes the head record
- out_inst, out_pc, out_counter, out_wen, out_wdst, out_wdata, out_jump_en, out_jump_target  out  32/64/64/1/5/64/1/64  head record fields
- retired  out  64  records popped since reset
- seq_err  out  1  sticky: counter gap or reorder detected
- halted  out  1  sticky: HALT_INST has been popped

Behaviour:
- Reset (async, takes effect immediately):
  - FIFO empty; all out_* = 0; retired = 0; seq_err = 0; halted = 0.
  - Expected counter = 0; internal halt_seen = 0.
- Push:
  - Condition: in_valid && in_ready.
  - in_ready = !full && !halt_seen.
  - Writes the record at the tail.
  - in_wen is stored as in_wen && (in_wdst != 0); x0 writes are never reported.
- Sequence check on push:
  - If in_counter != expected, set seq_err (sticky until reset); the record is still enqueued.
  - expected <= in_counter + 1 in either case.
- Halt:
  - A pushed record with in_inst == HALT_INST sets halt_seen.
  - After that, in_ready = 0 permanently until reset; the trap record itself is accepted.
- Pop:
  - Condition: out_valid && out_ready.
  - out_valid = !empty; out_* fields are driven from the head entry.
  - out_* are zero when empty, so a sink never sees stale data.
  - Each pop increments retired (64-bit, wraps modulo 2^64).
  - Popping a record whose inst == HALT_INST sets halted in the following cycle.
- Latency:
  - Minimum 1 cycle from push to out_valid; no combinational in-to-out bypass.
  - Head stays stable while out_valid && !out_ready.
- Simultaneous push and pop:
  - When not full: occupancy unchanged.
  - When full: in_ready is already 0, so no push occurs; in_ready does not depend on out_ready.
- Pointers and occupancy:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Occupancy counter is log2(DEPTH)+1 bits; full = (count == DEPTH), empty = (count == 0).
- Ignored inputs: in_valid while !in_ready is ignored, with no side effects on expected or seq_err.
- Reset mid-stream discards all entries; the next accepted record must carry counter 0 to avoid seq_err.

Test Plan:
- Push counters 0,1,2 with out_ready=1 -> out_valid first high one cycle after first push; out_counter 0,1,2 in order; retired=3; seq_err=0.
- out_ready=0, push 5 records (DEPTH=4) -> in_ready falls after 4th accept; 5th held; out_counter stays 0. Raise out_ready -> drains 0..4 in order, no loss or duplication.
- Push counters 0,1,3 -> seq_err rises the cycle after counter 3 is accepted; all three records still emerge; seq_err stays 1 until reset.
- Push in_wen=1, in_wdst=0, in_wdata=64'hdead -> out_wen=0, out_wdst=0, out_wdata=64'hdead.
- Push counter 0 normal, counter 1 with inst 32'h0005006b, then hold in_valid -> in_ready=0 after the trap; halted=1 the cycle after the trap pops; retired=2.
- Fill 3 entries, assert reset mid-cycle -> out_valid=0 and retired=0 immediately. Push counter 0 after release -> seq_err=0.
